// File: rtl/fog_pkg.sv
// Shared types and helpers for the fibre-optic gyro loop emulator: FSM encoding,
// ADC saturation limits and the loop-delay legalisation rule.
package fog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } fog_state_t;

  // Largest and smallest two's-complement values of a 'bits'-wide ADC word.
  function automatic int sat_max(input int bits);
    return (1 <<< (bits - 1)) - 1;
  endfunction

  function automatic int sat_min(input int bits);
    return -(1 <<< (bits - 1));
  endfunction

  // A zero transit time is meaningless for a fibre loop; it behaves as one clock.
  function automatic logic [7:0] eff_delay(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

endpackage

// File: rtl/fog_delay_ram.sv
// Fibre-loop delay line: single-clock simple dual-port RAM with registered read.
module fog_delay_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset so it maps onto block RAM; only the
  // read register, which feeds the datapath, is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fog_loop_emulator.sv
// Closed-loop FOG plant emulator: delays the modulation code by the loop transit
// time and produces the demodulated phase difference as an ADC sample.
module fog_loop_emulator
  import fog_pkg::*;
#(
  parameter int DAC_BIT     = 16,
  parameter int ADC_BIT     = 14,
  parameter int DELAY_DEPTH = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic signed [DAC_BIT-1:0] i_dac_data,
  input  logic        [7:0]         i_delay_cnt,
  input  logic signed [15:0]        i_rate,
  input  logic        [3:0]         i_gain_shift,
  input  logic signed [ADC_BIT-1:0] i_bias,
  output logic signed [ADC_BIT-1:0] o_adc_data,
  output logic                      o_valid,
  output logic                      o_sat
);

  localparam int AW     = $clog2(DELAY_DEPTH);
  localparam int DIFF_W = DAC_BIT + 1;
  localparam int SUM_W  = DAC_BIT + 2;
  localparam int RES_W  = (DAC_BIT + 3 > ADC_BIT + 1) ? DAC_BIT + 3 : ADC_BIT + 1;

  localparam logic signed [RES_W-1:0] SAT_HI = RES_W'(sat_max(ADC_BIT));
  localparam logic signed [RES_W-1:0] SAT_LO = RES_W'(sat_min(ADC_BIT));

  fog_state_t state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    fill_cnt;
  logic [7:0]    delay_q;
  logic [7:0]    delay_in;
  logic          write_en;

  assign delay_in = eff_delay(i_delay_cnt);
  assign write_en = i_en && (state != ST_IDLE);
  assign rd_ptr   = wr_ptr - AW'(delay_q);

  // NOTE: every register in a clocked block uses <= so all of them update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      delay_q  <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + AW'(1);
      if (!i_en) begin
        state    <= ST_IDLE;
        fill_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            delay_q  <= delay_in;
          end
          ST_FILL, ST_RUN: begin
            // A new transit time invalidates the loop contents: refill from scratch.
            if (delay_in != delay_q) begin
              state    <= ST_FILL;
              fill_cnt <= '0;
              delay_q  <= delay_in;
            end else if (state == ST_FILL) begin
              fill_cnt <= fill_cnt + 8'd1;
              if (({1'b0, fill_cnt} + 9'd1) >= {1'b0, delay_q}) state <= ST_RUN;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage 1: current code alongside the code that entered the loop delay_q clocks ago.
  logic signed [DAC_BIT-1:0] dac_q;
  logic signed [DAC_BIT-1:0] old_q;
  logic                      run_q;

  fog_delay_ram #(
    .WIDTH (DAC_BIT),
    .DEPTH (DELAY_DEPTH),
    .ADDR_W(AW)
  ) u_delay_ram (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .we     (write_en),
    .wr_addr(wr_ptr),
    .wr_data(i_dac_data),
    .rd_addr(rd_ptr),
    .rd_data(old_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dac_q <= '0;
      run_q <= 1'b0;
    end else begin
      dac_q <= i_dac_data;
      run_q <= (state == ST_RUN);
    end
  end

  // Stage 2: phase difference plus rotation term, scaled, offset and clipped.
  logic signed [DIFF_W-1:0]  diff;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   scaled;
  logic signed [RES_W-1:0]   res;
  logic signed [ADC_BIT-1:0] res_clip;
  logic                      res_ovf;

  assign diff   = DIFF_W'(dac_q) - DIFF_W'(old_q);
  assign sum    = SUM_W'(diff) + SUM_W'(i_rate);
  assign scaled = sum >>> i_gain_shift;
  assign res    = RES_W'(scaled) + RES_W'(i_bias);

  // NOTE: defaults first, so every path assigns both outputs and no latch appears.
  always_comb begin
    res_clip = res[ADC_BIT-1:0];
    res_ovf  = 1'b0;
    if (res > SAT_HI) begin
      res_clip = SAT_HI[ADC_BIT-1:0];
      res_ovf  = 1'b1;
    end else if (res < SAT_LO) begin
      res_clip = SAT_LO[ADC_BIT-1:0];
      res_ovf  = 1'b1;
    end
  end

  // Leaving RUN drops the in-flight sample immediately rather than draining it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_adc_data <= '0;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
    end else if (run_q && (state == ST_RUN)) begin
      o_adc_data <= res_clip;
      o_valid    <= 1'b1;
      o_sat      <= res_ovf;
    end else begin
      o_adc_data <= i_bias;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fog_loop_emulator.sv
// Self-checking bench: directed loop scenarios plus randomized traffic, with a
// sample-history reference model compared against the DUT on every clock.
module tb_fog_loop_emulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic signed [15:0] dac = '0;
  logic        [7:0]  dly = '0;
  logic signed [15:0] rate = '0;
  logic        [3:0]  shift = '0;
  logic signed [13:0] bias = '0;
  logic signed [13:0] adc;
  logic               valid;
  logic               sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fog_loop_emulator dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_dac_data  (dac),
    .i_delay_cnt (dly),
    .i_rate      (rate),
    .i_gain_shift(shift),
    .i_bias      (bias),
    .o_adc_data  (adc),
    .o_valid     (valid),
    .o_sat       (sat)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a history of every loop write, the current fill segment,
  // and a one-sample record of what the previous clock would produce.
  int hist[$];
  bit seg_on;
  int seg_writes;
  int cur_d;
  bit p_run;
  int p_dac, p_old;
  bit exp_valid, exp_sat;
  int exp_data;
  int m_eff, m_res, m_old;
  bit m_run;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      seg_on = 1'b0; seg_writes = 0; cur_d = 1;
      p_run = 1'b0; p_dac = 0; p_old = 0;
      exp_valid = 1'b0; exp_sat = 1'b0; exp_data = 0;
    end else begin
      m_eff = (dly == 8'd0) ? 1 : int'(dly);
      m_run = seg_on && (seg_writes >= cur_d);
      if (p_run && m_run) begin
        m_res = ((p_dac - p_old + int'(rate)) >>> shift) + int'(bias);
        exp_sat = 1'b0;
        if (m_res > 8191) begin
          m_res = 8191; exp_sat = 1'b1;
        end else if (m_res < -8192) begin
          m_res = -8192; exp_sat = 1'b1;
        end
        exp_valid = 1'b1;
        exp_data  = m_res;
      end else begin
        exp_valid = 1'b0; exp_sat = 1'b0; exp_data = int'(bias);
      end
      m_old = (m_run && en) ? hist[hist.size() - cur_d] : 0;
      if (!en) begin
        seg_on = 1'b0;
      end else if (!seg_on) begin
        seg_on = 1'b1; seg_writes = 0; cur_d = m_eff;
      end else begin
        hist.push_back(int'(dac));
        if (hist.size() > 300) hist.delete(0);
        if (m_eff != cur_d) begin
          cur_d = m_eff; seg_writes = 0;
        end else begin
          seg_writes++;
        end
      end
      p_run = m_run; p_dac = int'(dac); p_old = m_old;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("stream_valid", valid, exp_valid);
      check("stream_data", adc, exp_data);
      check("stream_sat", sat, exp_sat);
    end else begin
      check("stream_rst_valid", valid, 0);
      check("stream_rst_data", adc, 0);
      check("stream_rst_sat", sat, 0);
    end
  end

  // Counts clock edges until o_valid rises, bounded so a dead DUT cannot hang the run.
  task automatic count_to_valid(input int start, output int n);
    n = start;
    while (!valid && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  int cnt, bad, flips, last_sign, vcnt;

  initial begin
    // Reset state, with a nonzero bias that must not leak through reset.
    bias = 14'sd55;
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_data", adc, 0);
    check("reset_sat", sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_bias", adc, 55);
    check("idle_valid", valid, 0);

    // Constant code, delay 10: valid 12 clocks after entering FILL, zero output.
    bias = '0; dac = 16'sd1000; dly = 8'd10; en = 1'b1;
    @(negedge clk);
    check("fill_no_valid", valid, 0);
    count_to_valid(0, cnt);
    check("fill_latency_d10", cnt, 12);
    check("const_dac_out", adc, 0);

    // Step 0 -> 4000: ten samples of 4000, two clocks after the step.
    dac = 16'sd0;
    repeat (15) @(negedge clk);
    dac = 16'sd4000;
    @(negedge clk);
    check("step_pre", adc, 0);
    @(negedge clk);
    cnt = 0;
    while (adc == 14'sd4000 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("step_width", cnt, 10);
    check("step_after", adc, 0);

    // Rotation term: clip at full scale, recover with a gain shift.
    rate = 16'sd32767;
    repeat (3) @(negedge clk);
    check("rate_pos_data", adc, 8191);
    check("rate_pos_sat", sat, 1);
    shift = 4'd4;
    repeat (3) @(negedge clk);
    check("rate_shift_data", adc, 2047);
    check("rate_shift_sat", sat, 0);
    rate = -16'sd32768; shift = 4'd0;
    repeat (3) @(negedge clk);
    check("rate_neg_data", adc, -8192);
    check("rate_neg_sat", sat, 1);

    // Delay change 10 -> 50 mid-RUN.
    rate = '0; bias = 14'sd123;
    repeat (3) @(negedge clk);
    check("bias_run_data", adc, 123);
    dly = 8'd50;
    @(negedge clk);
    @(negedge clk);
    check("redelay_valid_low", valid, 0);
    check("redelay_bias", adc, 123);
    count_to_valid(1, cnt);
    check("fill_latency_d50", cnt, 52);
    check("redelay_data", adc, 123);

    // Asynchronous reset mid-RUN, then a full refill.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_data", adc, 0);
    check("async_rst_sat", sat, 0);
    dly = 8'd10;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    count_to_valid(0, cnt);
    check("refill_latency", cnt, 12);
    check("refill_data", adc, 123);

    // Delay 0 behaves as 1.
    en = 1'b0;
    @(negedge clk);
    dly = 8'd0; en = 1'b1;
    @(negedge clk);
    count_to_valid(0, cnt);
    check("delay0_latency", cnt, 3);

    // Delay 255 with a +/-2000 square wave of period 510: output is +/-4000 across pointer wrap.
    en = 1'b0; bias = '0;
    @(negedge clk);
    dly = 8'd255; en = 1'b1;
    bad = 0; flips = 0; last_sign = 0; vcnt = 0;
    for (int k = 0; k < 855; k++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        if (adc == 14'sd4000 || adc == -14'sd4000) begin
          if (last_sign != 0 && (adc > 0 ? 1 : -1) != last_sign) flips++;
          last_sign = (adc > 0) ? 1 : -1;
        end else begin
          bad++;
        end
      end
      dac = (((k / 255) % 2) == 0) ? 16'sd2000 : -16'sd2000;
    end
    check("wrap_bad_samples", bad, 0);
    check("wrap_sign_flips", flips, 2);
    check("wrap_valid_count_ok", (vcnt >= 590) ? 1 : 0, 1);

    // Randomized traffic against the model.
    en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      dac = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 4))
          0:       dly = 8'd0;
          1:       dly = 8'($urandom_range(1, 4));
          2, 3:    dly = 8'($urandom_range(5, 60));
          default: dly = 8'd255;
        endcase
      end
      if ($urandom_range(0, 299) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        rate  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
        shift = 4'($urandom_range(0, 15));
        bias  = 14'($urandom);
      end
    end

    en = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
